// File: rtl/axi_fanin_arb_ctrl.sv
// Sequencing controller for a binary tree of 2:1 request fan-in nodes.
// Drives the per-level round-robin flag bits, locks the tree onto an
// exclusive winner until it releases or goes idle too long, and flags
// grant anomalies.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   gnt_vec_i    - per-initiator grant from the tree leaves
//   excl_vec_i   - per-initiator exclusive attribute of the current request
//   release_i    - pulse: lock owner's exclusive sequence is complete
//   rr_flag_o    - round-robin pointer, bit L feeds tree level L
//   lock_o       - forces all tree nodes into exclusive mode
//   sel_o        - lock owner index, bit L feeds exclusive select of level L
//   timeout_o    - one-cycle pulse on forced release
//   grant_err_o  - one-cycle pulse: multi-hot or non-owner grant last cycle
module axi_fanin_arb_ctrl #(
  parameter int unsigned N_INIT       = 4,
  parameter int unsigned LOG_N_INIT   = 2,
  parameter int unsigned TIMER_WIDTH  = 8,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_INIT-1:0]     gnt_vec_i,
  input  logic [N_INIT-1:0]     excl_vec_i,
  input  logic                  release_i,
  output logic [LOG_N_INIT-1:0] rr_flag_o,
  output logic                  lock_o,
  output logic [LOG_N_INIT-1:0] sel_o,
  output logic                  timeout_o,
  output logic                  grant_err_o
);

  localparam logic [TIMER_WIDTH-1:0] TimerLast = TIMER_WIDTH'(LOCK_TIMEOUT - 1);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e                  state_q, state_d;
  logic [LOG_N_INIT-1:0]   rr_q, rr_d;
  logic [LOG_N_INIT-1:0]   sel_q, sel_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic                    timeout_q, timeout_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    multi;
  logic                    owner_acc;
  logic [LOG_N_INIT-1:0]   win;

  assign accept = |gnt_vec_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi  = (gnt_vec_i & (gnt_vec_i - 1'b1)) != '0;

  // Lowest set bit wins; scan downwards so the lowest index is written last.
  always_comb begin
    win = '0;
    for (int k = N_INIT - 1; k >= 0; k--) begin
      if (gnt_vec_i[k]) win = LOG_N_INIT'(k);
    end
  end

  assign owner_acc = accept && (win == sel_q);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    err_d     = multi;
    unique case (state_q)
      StArb: begin
        if (accept) begin
          // Power-of-two width makes the increment wrap modulo N_INIT.
          rr_d = rr_q + 1'b1;
          if (excl_vec_i[win]) begin
            state_d = StLocked;
            sel_d   = win;
            timer_d = '0;
          end
        end
      end
      StLocked: begin
        // A grant to anyone but the owner means the tree ignored the lock.
        if (accept && !owner_acc) err_d = 1'b1;
        if (release_i) begin
          state_d = StArb;
          timer_d = '0;
        end else if (timer_q == TimerLast && !owner_acc) begin
          state_d   = StArb;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else if (owner_acc) begin
          timer_d = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StArb;
      rr_q      <= '0;
      sel_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign rr_flag_o   = rr_q;
  assign lock_o      = (state_q == StLocked);
  assign sel_o       = sel_q;
  assign timeout_o   = timeout_q;
  assign grant_err_o = err_q;

endmodule

// File: tb/tb_axi_fanin_arb_ctrl.sv
module tb_axi_fanin_arb_ctrl;

  localparam int N  = 4;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] gnt_vec_i = '0;
  logic [3:0] excl_vec_i = '0;
  logic       release_i = 1'b0;
  logic [1:0] rr_flag_o;
  logic       lock_o;
  logic [1:0] sel_o;
  logic       timeout_o;
  logic       grant_err_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_rr, m_sel, m_idle;
  bit m_locked, m_to, m_err;

  axi_fanin_arb_ctrl #(
    .N_INIT      (4),
    .LOG_N_INIT  (2),
    .TIMER_WIDTH (8),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gnt_vec_i  (gnt_vec_i),
    .excl_vec_i (excl_vec_i),
    .release_i  (release_i),
    .rr_flag_o  (rr_flag_o),
    .lock_o     (lock_o),
    .sel_o      (sel_o),
    .timeout_o  (timeout_o),
    .grant_err_o(grant_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rr"},   int'(rr_flag_o),   m_rr);
    check({tag, ".lock"}, int'(lock_o),      int'(m_locked));
    if (m_locked) check({tag, ".sel"}, int'(sel_o), m_sel);
    check({tag, ".to"},   int'(timeout_o),   int'(m_to));
    check({tag, ".err"},  int'(grant_err_o), int'(m_err));
  endtask

  task automatic model_reset();
    m_rr = 0; m_sel = 0; m_idle = 0; m_locked = 0; m_to = 0; m_err = 0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step(input logic [3:0] g, input logic [3:0] x, input bit rel);
    int  w;
    int  ones;
    bit  acc;
    bit  own;
    w = -1; ones = 0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        ones++;
        if (w < 0) w = i;
      end
    end
    acc   = (ones > 0);
    m_to  = 0;
    m_err = (ones > 1) || (m_locked && acc && w != m_sel);
    if (!m_locked) begin
      if (acc) begin
        m_rr = (m_rr + 1) % N;
        if (x[w]) begin
          m_locked = 1; m_sel = w; m_idle = 0;
        end
      end
    end else begin
      own = acc && (w == m_sel);
      if (rel) begin
        m_locked = 0; m_idle = 0;
      end else if (m_idle == TO - 1 && !own) begin
        m_locked = 0; m_idle = 0; m_to = 1;
      end else if (own) begin
        m_idle = 0;
      end else if (m_idle < 255) begin
        m_idle++;
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] x, input bit rel);
    @(negedge clk);
    gnt_vec_i = g; excl_vec_i = x; release_i = rel;
    @(posedge clk);
    model_step(g, x, rel);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    logic [3:0] g, x;
    bit r;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: plain round robin with wrap
    step("rr0", 4'b0001, 4'b0000, 0);
    step("rr1", 4'b0010, 4'b0000, 0);
    step("rr2", 4'b0100, 4'b0000, 0);
    step("rr3", 4'b1000, 4'b0000, 0);
    step("rr4", 4'b0001, 4'b0000, 0);
    check("rr_wrap", int'(rr_flag_o), 1);

    // 2: lock on 2, owner grants, release
    step("lk2", 4'b0100, 4'b0100, 0);
    check("lk2_sel", int'(sel_o), 2);
    step("own_a", 4'b0100, 4'b0000, 0);
    step("own_b", 4'b0100, 4'b0000, 0);
    step("own_c", 4'b0100, 4'b0000, 0);
    step("rel2",  4'b0000, 4'b0000, 1);
    check("rel2_lock", int'(lock_o), 0);

    // 3: timeout, plain then restarted by an owner grant
    step("lk1", 4'b0010, 4'b0010, 0);
    idle("to_wait", TO);
    check("to_pulse", int'(timeout_o), 1);
    idle("to_after", 1);
    step("lk1b", 4'b0010, 4'b0010, 0);
    idle("rs_wait", 1);
    step("rs_own", 4'b0010, 4'b0000, 0);
    idle("rs_wait2", TO);
    check("rs_pulse", int'(timeout_o), 1);

    // 4: multi-hot in ARB, foreign grant in LOCKED
    step("multi", 4'b0110, 4'b0000, 0);
    check("multi_err", int'(grant_err_o), 1);
    step("lk1c", 4'b0010, 4'b0010, 0);
    step("foreign", 4'b1000, 4'b0000, 0);
    check("foreign_err", int'(grant_err_o), 1);
    idle("fg_wait", 2);

    // 5: owner grant plus release at last timer value
    step("lk1d", 4'b0010, 4'b0010, 0);
    idle("t5_wait", TO - 1);
    step("t5_rel", 4'b0010, 4'b0000, 1);
    check("t5_noto", int'(timeout_o), 0);
    idle("t5_after", 1);

    // 6: async reset while locked
    step("lk3", 4'b1000, 4'b1000, 0);
    @(posedge clk);
    model_step(4'b0000, 4'b0000, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_lock", int'(lock_o), 0);
    check("ar_rr",   int'(rr_flag_o), 0);
    check("ar_sel",  int'(sel_o), 0);
    check("ar_to",   int'(timeout_o), 0);
    @(negedge clk);
    gnt_vec_i = '0; excl_vec_i = '0; release_i = 1'b0;
    rst_n = 1'b1;

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      int c;
      c = $urandom_range(0, 9);
      if (c < 3) g = 4'b0000;
      else if (c < 8) g = 4'(1 << $urandom_range(0, 3));
      else g = 4'($urandom_range(1, 15));
      if (m_locked && $urandom_range(0, 1) == 1) g = 4'(1 << m_sel);
      x = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      r = ($urandom_range(0, 7) == 0);
      step("rand", g, x, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_fanin_arb_ctrl.md
Name: axi_fanin_arb_ctrl

Overview:
- Sequencing controller for a binary tree of 2:1 request fan-in primitives in the AXI node, which share one target port among N_INIT initiators.
- Drives the per-level round-robin flag bits to the tree.
- When an exclusive request wins, it locks the tree onto that initiator by driving the tree's exclusive-lock and exclusive-select inputs, and holds the lock until released or timed out.
- Reports protocol anomalies (multi-hot grant, lock timeout).

Parameters:
- N_INIT, 4, number of initiators; power of two, >= 2.
- LOG_N_INIT, 2, log2(N_INIT); width of the round-robin pointer and the select.
- TIMER_WIDTH, 8, width of the lock-inactivity timer.
- LOCK_TIMEOUT, 255, idle cycles in LOCKED with no accept before forced release; must be >= 1.

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- gnt_vec_i, input, N_INIT, per-initiator grants from the tree leaves; bit k set = initiator k's request accepted this cycle.
- excl_vec_i, input, N_INIT, per-initiator exclusive/locked attribute of the current request.
- release_i, input, 1, single-cycle pulse: the exclusive sequence of the lock owner is complete.
- rr_flag_o, output, LOG_N_INIT, round-robin pointer; bit L feeds the RR flag of every tree node at level L.
- lock_o, output, 1, forces all tree nodes into exclusive mode.
- sel_o, output, LOG_N_INIT, lock owner index; bit L feeds the exclusive select of level L.
- timeout_o, output, 1, one-cycle pulse on forced release.
- grant_err_o, output, 1, one-cycle pulse, registered, when gnt_vec_i had more than one bit set in the previous cycle.

Behaviour:
- Reset (async, while rst_n = 0): state = ARB; rr_flag_o = 0; lock_o = 0; sel_o = 0; timer = 0; timeout_o = 0; grant_err_o = 0. Reset mid-LOCKED drops the lock immediately, with no timeout pulse.
- accept = |gnt_vec_i.
- win = index of the lowest set bit of gnt_vec_i.
- multi = more than one bit of gnt_vec_i set. grant_err_o is asserted the next cycle; win still uses the lowest set bit.
- All outputs are registered. lock_o and sel_o change only on clock edges.

State ARB (lock_o = 0):
- On accept: rr_flag_o <= rr_flag_o + 1, modulo N_INIT (wraps from N_INIT-1 to 0).
- If accept and excl_vec_i[win] = 1: next state LOCKED, sel_o <= win, lock_o <= 1, timer <= 0. rr_flag_o still advances on this accept.
- release_i is ignored in ARB.

State LOCKED (lock_o = 1):
- rr_flag_o is frozen.
- An accept with win == sel_o resets the timer to 0.
- An accept from any other index is a tree fault. It sets grant_err_o next cycle and does not reset the timer.
- If release_i = 1: next state ARB, lock_o <= 0, timer <= 0. This applies even if an accept occurs in the same cycle; that accept is counted, but rr_flag_o does not advance.
- Else if timer == LOCK_TIMEOUT - 1 and there is no owner accept this cycle: next state ARB, lock_o <= 0, timeout_o <= 1 for one cycle.
- Else, with no owner accept: timer <= timer + 1, saturating at all-ones.
- Release takes priority over timeout in the same cycle; no timeout_o pulse is generated.
- sel_o holds its value after returning to ARB (don't-care when lock_o = 0).

Latency:
- Lock asserts the cycle after the winning exclusive accept. The tree must therefore tolerate one unlocked cycle; the next grant goes to the owner because of lock_o.
- An exclusive request and its release in consecutive cycles is legal: one LOCKED cycle.

Test Plan:
1. Reset, then single-hot grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, excl = 0 -> rr_flag_o = 1, 2, 3, 0, 1 one cycle after each grant; lock_o stays 0.
2. gnt_vec_i = 0100 with excl_vec_i = 0100 -> next cycle lock_o = 1, sel_o = 2, rr_flag_o advanced by 1. Three owner grants follow, then release_i -> lock_o = 0 the cycle after release; rr_flag_o unchanged throughout LOCKED.
3. LOCK_TIMEOUT = 4: lock on initiator 1, no further grants, no release -> lock_o drops and timeout_o pulses exactly 4 cycles after lock_o rose. An owner grant at cycle 2 of LOCKED restarts the count.
4. gnt_vec_i = 0110 in ARB -> grant_err_o pulses once next cycle; win = 1; rr_flag_o advances by 1. In LOCKED with sel_o = 1, a grant of 1000 -> grant_err_o pulses; timer not cleared.
5. Same cycle in LOCKED: owner grant plus release_i with timer at LOCK_TIMEOUT-1 -> clean release, timeout_o = 0.
6. rst_n asserted asynchronously mid-cycle while LOCKED -> lock_o, rr_flag_o and sel_o go to 0 without waiting for a clock edge; no timeout_o pulse.
